// File: rtl/field_pack_pkg.sv
// Shared widths, derived word geometry and state encoding for the field packing
// sequencer and anything that rebuilds its words (e.g. the byte link checker).
package field_pack_pkg;
  localparam int FIELD_W    = 5;
  localparam int NUM_FIELDS = 6;
  localparam int PAD_W      = 2;
  localparam logic [PAD_W-1:0] PAD_VAL = 2'b11;

  localparam int WORD_W    = FIELD_W * NUM_FIELDS + PAD_W;
  localparam int OUT_BYTES = WORD_W / 8;
  localparam int CNT_W     = $clog2(NUM_FIELDS + 1);
  localparam int BIDX_W    = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  typedef enum logic {COLLECT, EMIT} seq_state_t;
endpackage

// File: rtl/field_pack_sequencer_if.sv
// Field input stream and byte output stream of the packing sequencer.
interface field_pack_sequencer_if;
  import field_pack_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [FIELD_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_data;
  logic               out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/field_word_assembler.sv
// Combinational packer: slot 0 lands in the MSBs, the pad fills the LSBs.
module field_word_assembler
  import field_pack_pkg::*;
(
  input  logic [FIELD_W-1:0] slots [NUM_FIELDS],
  input  logic [PAD_W-1:0]   pad,
  output logic [WORD_W-1:0]  word
);
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      word[WORD_W-1-i*FIELD_W -: FIELD_W] = slots[i];
    end
    word[PAD_W-1:0] = pad;
  end
endmodule

// File: rtl/field_pack_sequencer.sv
// Collects NUM_FIELDS fields into a padded word, then streams it out as bytes,
// MSB byte first. Collection and emission never overlap.
module field_pack_sequencer
  import field_pack_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  field_pack_sequencer_if.slave bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      field_cnt
);
  if ((WORD_W % 8) != 0) begin : g_bad_geometry
    $error("field_pack_sequencer: FIELD_W*NUM_FIELDS+PAD_W must be a multiple of 8");
  end

  seq_state_t         state;
  logic [FIELD_W-1:0] slot_q [NUM_FIELDS-1];
  logic [FIELD_W-1:0] load_slots [NUM_FIELDS];
  logic [WORD_W-1:0]  load_word;
  logic [WORD_W-1:0]  word_q;
  logic [BIDX_W-1:0]  byte_idx;
  logic [7:0]         out_data_q;
  logic               out_valid_q;
  logic               out_last_q;

  // The final field comes straight from the bus so the load never sees a stale slot.
  always_comb begin
    for (int i = 0; i < NUM_FIELDS - 1; i++) begin
      load_slots[i] = slot_q[i];
    end
    load_slots[NUM_FIELDS-1] = bus.in_data;
  end

  field_word_assembler u_assembler (
    .slots (load_slots),
    .pad   (PAD_VAL),
    .word  (load_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= COLLECT;
      field_cnt   <= '0;
      byte_idx    <= '0;
      word_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < NUM_FIELDS - 1; i++) begin
        slot_q[i] <= '0;
      end
    end else if (clear) begin
      state       <= COLLECT;
      field_cnt   <= '0;
      byte_idx    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.in_valid) begin
            if (field_cnt == CNT_W'(NUM_FIELDS - 1)) begin
              state       <= EMIT;
              field_cnt   <= '0;
              byte_idx    <= '0;
              out_data_q  <= load_word[WORD_W-1 -: 8];
              word_q      <= load_word << 8;
              out_valid_q <= 1'b1;
              out_last_q  <= (OUT_BYTES == 1);
            end else begin
              field_cnt <= field_cnt + CNT_W'(1);
              for (int i = 0; i < NUM_FIELDS - 1; i++) begin
                if (field_cnt == CNT_W'(i)) slot_q[i] <= bus.in_data;
              end
            end
          end
        end
        EMIT: begin
          if (out_valid_q && bus.out_ready) begin
            if (out_last_q) begin
              state       <= COLLECT;
              byte_idx    <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              byte_idx   <= byte_idx + BIDX_W'(1);
              out_data_q <= word_q[WORD_W-1 -: 8];
              word_q     <= word_q << 8;
              out_last_q <= (byte_idx == BIDX_W'(OUT_BYTES - 2));
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = (state == COLLECT);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state != COLLECT) || (field_cnt != '0);
endmodule

// File: doc/field_pack_sequencer.md
Name: field_pack_sequencer

Overview:
Sequences the team's 6×5-bit field packing datapath.
- Collects six 5-bit fields, one per handshake, over a valid/ready input stream.
- Assembles them into a 32-bit word: first field in the MSBs, then the 2-bit pad constant 2'b11 in the LSBs.
- Emits the word as four bytes, MSB byte first, on a valid/ready byte stream.
- Sits between a field producer and a byte-wide link/serializer.

Parameters:
- FIELD_W, 5, width of each input field.
- NUM_FIELDS, 6, fields per word.
- PAD_W, 2, width of the LSB pad.
- PAD_VAL, 2'b11, pad value.
- Constraint: FIELD_W*NUM_FIELDS+PAD_W must be a multiple of 8. OUT_BYTES = that total / 8 (4 at defaults). Elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort; discards the partial or unsent word.
- in_valid  in  1  field available.
- in_ready  out  1  block accepts a field this cycle.
- in_data  in  FIELD_W  field value.
- out_valid  out  1  byte available.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  8  byte value.
- out_last  out  1  high with the final byte of the word.
- busy  out  1  high when state≠COLLECT or field_cnt≠0.
- field_cnt  out  clog2(NUM_FIELDS+1)  fields captured in the current word.

Behaviour:
- States: COLLECT, EMIT.
- Reset (asynchronous, any time, including mid-word) forces:
  - state=COLLECT, field_cnt=0, byte index=0, word register=0;
  - out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1.
- COLLECT:
  - in_ready=1 (combinational from state only; never depends on in_valid).
  - in_valid&&in_ready at an edge stores in_data into slot field_cnt (slot 0 = MSB field) and increments field_cnt.
  - On acceptance of field NUM_FIELDS-1, the next state is EMIT and field_cnt returns to 0.
  - At that edge the word register is loaded as {slot0..slot5, PAD_VAL}; the final field is bypassed into the load directly, not taken from a stale slot.
- EMIT:
  - in_ready=0.
  - out_valid is registered high, out_data = word[31:24] first, then [23:16], [15:8], [7:0].
  - A byte advances only on out_valid&&out_ready.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0 (no retraction).
  - out_last=1 only with the final byte.
  - Handshake on the final byte: the next state is COLLECT, out_valid=0 and out_last=0 at the next cycle.
- Latency: last field accepted at edge N → out_valid=1 with the first byte after edge N.
- Maximum rate: NUM_FIELDS+OUT_BYTES cycles per word. No overlap of collect and emit.
- clear:
  - Any state: at the next edge, state=COLLECT, field_cnt=0, byte index=0, out_valid=0, out_last=0.
  - clear with a simultaneous input handshake: clear wins and the field is dropped.
  - clear with a simultaneous output handshake: the byte counts as consumed by downstream, but the rest of the word is dropped.
- out_ready asserted while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored and not stored.
- Fields are truncated/zero-extended exactly as declared; no arithmetic is performed.

Decomposition:
- Shared package field_pack_pkg holds:
  - FIELD_W, NUM_FIELDS, PAD_W, PAD_VAL defaults;
  - derived WORD_W=32 and OUT_BYTES=4;
  - the state enum {COLLECT, EMIT}.
- One sub-module, field_word_assembler: purely combinational; slot array plus pad → WORD_W-bit word. It is reused by the byte link checker.
- FSM, counters and output register stay in field_pack_sequencer.

Test Plan:
- Fields 01,02,03,04,05,06, out_ready=1 → bytes 08,86,42,9B; out_last on 9B; out_valid first high 1 cycle after the 6th accept; 10 cycles total.
- Fields 1F,00,15,0A,1F,00 with out_ready toggling 1,0,0,1… → bytes F8,2A,AF,83. out_data/out_last stable during stall cycles. in_ready=0 throughout EMIT.
- All fields 00 → 00,00,00,03. All fields 1F → FF,FF,FF,FF. Two words back-to-back; field_cnt returns to 0 between them.
- clear asserted with the 3rd field's handshake → field_cnt=0 next cycle, that field dropped. Next six fields 01..06 produce 08,86,42,9B.
- reset pulsed asynchronously mid-EMIT after byte 86 → out_valid=0, busy=0 immediately without a clock edge. Subsequent word is correct from byte 0.
- in_valid held high continuously with out_ready=0 for 20 cycles → only 6 fields accepted; byte 08 held with out_valid=1 until out_ready rises.
